// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   640x480@60 Hz VGA timing generator running entirely on the 100 MHz master
//   clock. A divide-by-4 pixel enable (optick) replaces a derived 25 MHz clock;
//   every downstream VGA block qualifies its logic on optick.
//
//   Optional feature macro: FRAME_PULSE_EN (adds the oframe output).
//
// Ports
//   iclk       in   1   master clock, all logic on posedge
//   irst_n     in   1   asynchronous active-low reset
//   optick     out  1   pixel enable, high one iclk cycle in every 4
//   opixel_x   out  10  horizontal count, 0..H_TOTAL-1
//   opixel_y   out  10  vertical count, 0..V_TOTAL-1
//   ohsync     out  1   horizontal sync, active-low
//   ovsync     out  1   vertical sync, active-low
//   ovideo_on  out  1   high while (x,y) is in the visible area
//   oframe     out  1   one-cycle pulse when the counters enter (0,0)
//                       (only with FRAME_PULSE_EN)

module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       iclk,
  input  logic       irst_n,
  output logic       optick,
  output logic [9:0] opixel_x,
  output logic [9:0] opixel_y,
  output logic       ohsync,
  output logic       ovsync,
  output logic       ovideo_on
`ifdef FRAME_PULSE_EN
  ,
  output logic       oframe
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // All compares are done at 10 bits, unsigned.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [1:0] div_q, div_d;
  logic       tick_q, tick_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_q, frame_d;

  always_comb begin
    div_d = div_q + 2'd1;
    // Registered from div==2 so the enable is high while div==3.
    tick_d = (div_q == 2'd2);

    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (tick_q) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = 10'd0;
        pixel_y_d = (pixel_y_q == V_LAST) ? 10'd0 : pixel_y_q + 10'd1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end
    end

    // Decodes use the next counter values so they line up with the
    // registered coordinates on the same edge.
    hsync_d    = !((pixel_x_d >= HS_START) && (pixel_x_d < HS_END));
    vsync_d    = !((pixel_y_d >= VS_START) && (pixel_y_d < VS_END));
    video_on_d = (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);
    frame_d    = tick_q && (pixel_x_d == 10'd0) && (pixel_y_d == 10'd0);
  end

  // Reset parks the counters on the last pixel of the frame so the first
  // advance lands on (0,0).
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      div_q      <= 2'd0;
      tick_q     <= 1'b0;
      pixel_x_q  <= H_LAST;
      pixel_y_q  <= V_LAST;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      frame_q    <= frame_d;
    end
  end

  assign optick    = tick_q;
  assign opixel_x  = pixel_x_q;
  assign opixel_y  = pixel_y_q;
  assign ohsync    = hsync_q;
  assign ovsync    = vsync_q;
  assign ovideo_on = video_on_q;

`ifdef FRAME_PULSE_EN
  assign oframe = frame_q;
`else
  logic unused_frame;
  assign unused_frame = frame_q;
`endif

endmodule
